// File: rtl/hydra_match_pkg.sv
// Shared types and helpers for the write-side SRAM match engine.
package hydra_match_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DONE_S = 2'd2,
    DONE_F = 2'd3
  } match_state_e;

  localparam int SRAM_NUM_DEF = 32;

  // "No SRAM" is encoded as the SRAM count itself, one past the last index.
  function automatic int unsigned no_sram(input int unsigned sram_num);
    return sram_num;
  endfunction

  // Packet length in bytes to required free space in half-words (len/8 + 1).
  function automatic logic [15:0] calc_need(input logic [15:0] len_bytes);
    return {3'b000, len_bytes[15:3]} + 16'd1;
  endfunction

endpackage

// File: rtl/match_rsp_pipe.sv
// Valid + index shift register that tags each status response with the
// SRAM index it belongs to, STAGES cycles after the index was issued.
module match_rsp_pipe #(
  parameter int STAGES = 1,
  parameter int IDX_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             vld_in,
  input  logic [IDX_W-1:0] idx_in,
  output logic             vld_out,
  output logic [IDX_W-1:0] idx_out
);

  logic [STAGES-1:0] vld_p;
  logic [IDX_W-1:0]  idx_p [STAGES];

  // Valid chain: cleared on reset and whenever the scan is left.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= vld_in;
      for (int i = 1; i < STAGES; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  // Index chain: plain data, qualified by the valid chain.
  always_ff @(posedge clk) begin
    idx_p[0] <= idx_in;
    for (int i = 1; i < STAGES; i++) begin
      idx_p[i] <= idx_p[i-1];
    end
  end

  assign vld_out = vld_p[STAGES-1];
  assign idx_out = idx_p[STAGES-1];

endmodule

// File: rtl/port_wr_sram_match_engine.sv
// Write-side SRAM matcher for one input port: scans all shared SRAMs
// round-robin and picks the accessible one with enough room that already
// holds the most packets for the destination port.
module port_wr_sram_match_engine
  import hydra_match_pkg::*;
#(
  parameter int SRAM_NUM = SRAM_NUM_DEF,
  parameter int IDX_W    = $clog2(SRAM_NUM),
  parameter int LEN_W    = 9,
  parameter int FREE_W   = 11,
  parameter int AMT_W    = 9,
  parameter int TICK_W   = 8,
  parameter int RSP_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TICK_W-1:0] match_threshold,
  input  logic [TICK_W-1:0] match_timeout,
  input  logic              early_exit_en,
  input  logic [LEN_W-1:0]  new_length,
  input  logic              match_enable,
  output logic              match_busy,
  output logic              match_suc,
  output logic              match_fail,
  output logic [IDX_W:0]    match_best_sram,
  output logic [IDX_W-1:0]  match_sram,
  input  logic              accessible,
  input  logic [FREE_W-1:0] free_space,
  input  logic [AMT_W-1:0]  packet_amount
);

  localparam logic [IDX_W:0]   NO_SRAM  = (IDX_W+1)'(no_sram(SRAM_NUM));
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SRAM_NUM - 1);
  localparam logic [IDX_W:0]   FULL_CNT = (IDX_W+1)'(SRAM_NUM);

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  match_state_e      state;
  logic [IDX_W-1:0]  start_ptr;
  logic [TICK_W-1:0] tick;
  logic [IDX_W:0]    eval_cnt;
  logic              found;
  logic [AMT_W-1:0]  best_amt;
  logic [FREE_W-1:0] need;

  logic              issue_vld;
  logic              pipe_flush;
  logic              rsp_vld;
  logic [IDX_W-1:0]  rsp_idx;
  logic              accept;
  logic              term_s;
  logic              term_f;
  logic              cand;
  logic              upd;

  assign issue_vld  = (state == SCAN);
  assign pipe_flush = (state != SCAN);

  match_rsp_pipe #(
    .STAGES (RSP_LAT),
    .IDX_W  (IDX_W)
  ) u_rsp_pipe (
    .clk     (clk),
    .rst     (rst),
    .flush   (pipe_flush),
    .vld_in  (issue_vld),
    .idx_in  (match_sram),
    .vld_out (rsp_vld),
    .idx_out (rsp_idx)
  );

  // Termination and candidate evaluation, from registered scan state.
  always_comb begin
    accept = (state == IDLE) && match_enable;
    term_s = found && ((tick >= match_threshold) ||
                       (early_exit_en && (eval_cnt == FULL_CNT)));
    term_f = (tick == match_timeout);
    cand   = rsp_vld && accessible && (free_space >= need);
    upd    = (state == SCAN) && match_enable && !term_s && !term_f && cand &&
             (!found || (packet_amount > best_amt));
  end

  // Request datapath: required space latched at accept, best amount tracked.
  always_ff @(posedge clk) begin
    if (accept) begin
      need     <= FREE_W'(calc_need(16'(new_length)));
      best_amt <= '0;
    end else if (upd) begin
      best_amt <= packet_amount;
    end
  end

  // Scan FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      match_busy      <= 1'b0;
      match_suc       <= 1'b0;
      match_fail      <= 1'b0;
      match_best_sram <= NO_SRAM;
      match_sram      <= '0;
      start_ptr       <= '0;
      tick            <= '0;
      eval_cnt        <= '0;
      found           <= 1'b0;
    end else begin
      match_suc  <= 1'b0;
      match_fail <= 1'b0;
      case (state)
        IDLE: begin
          if (match_enable) begin
            state           <= SCAN;
            match_busy      <= 1'b1;
            match_sram      <= start_ptr;
            tick            <= '0;
            eval_cnt        <= '0;
            found           <= 1'b0;
            match_best_sram <= NO_SRAM;
          end
        end
        SCAN: begin
          if (!match_enable) begin
            state           <= IDLE;
            match_busy      <= 1'b0;
            match_best_sram <= NO_SRAM;
          end else if (term_s) begin
            state      <= DONE_S;
            match_busy <= 1'b0;
            match_suc  <= 1'b1;
            start_ptr  <= next_idx(match_best_sram[IDX_W-1:0]);
          end else if (term_f) begin
            state           <= DONE_F;
            match_busy      <= 1'b0;
            match_fail      <= 1'b1;
            match_best_sram <= NO_SRAM;
            start_ptr       <= next_idx(start_ptr);
          end else begin
            match_sram <= next_idx(match_sram);
            if (tick != '1) begin
              tick <= tick + 1'b1;
            end
            if (rsp_vld && (eval_cnt != FULL_CNT)) begin
              eval_cnt <= eval_cnt + 1'b1;
            end
            if (upd) begin
              found           <= 1'b1;
              match_best_sram <= {1'b0, rsp_idx};
            end
          end
        end
        DONE_S, DONE_F: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/port_wr_sram_match_engine.md
Name: port_wr_sram_match_engine

Overview:
- Parametrised next-generation write-side SRAM matcher for one input port.
- On a match request for a new packet, it scans all SRAM_NUM shared SRAMs round-robin, driving the SRAM index itself. It picks the accessible SRAM with enough free space that already holds the most packets for the packet's destination port.
- Adds over the previous generation:
  - self-driven scan with a rotating start pointer;
  - configurable response latency;
  - a full-sweep early exit;
  - a hard timeout with a fail pulse;
  - clean abort.
- Sits between the port front end (request/result) and the SRAM status mux in the back end.

Parameters:
- SRAM_NUM, 32, number of shared SRAMs (≥2).
- IDX_W, $clog2(SRAM_NUM), SRAM index width.
- LEN_W, 9, packet length field width (bytes).
- FREE_W, 11, free-space width (half-words).
- AMT_W, 9, per-port packet count width.
- TICK_W, 8, scan tick counter width.
- RSP_LAT, 1, cycles from match_sram driven to status inputs valid (1..3).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- match_threshold  in  TICK_W  minimum scan ticks before a found result may complete
- match_timeout  in  TICK_W  tick at which a scan with no result fails; must be ≥ match_threshold
- early_exit_en  in  1  allow completion once every SRAM has been evaluated
- new_length  in  LEN_W  packet length; sampled at request accept
- match_enable  in  1  level request; dropping it aborts
- match_busy  out  1  high in SCAN
- match_suc  out  1  one-cycle success pulse
- match_fail  out  1  one-cycle timeout pulse
- match_best_sram  out  IDX_W+1  chosen SRAM; SRAM_NUM = none
- match_sram  out  IDX_W  SRAM index currently queried
- accessible  in  1  status for index sent RSP_LAT cycles earlier
- free_space  in  FREE_W  same timing as accessible
- packet_amount  in  AMT_W  same timing as accessible

Behaviour:
- Reset values: state=IDLE, match_busy=0, match_suc=0, match_fail=0, match_best_sram=SRAM_NUM, match_sram=0, start_ptr=0, all pipeline valids=0.
- States:
  - IDLE → SCAN when match_enable=1.
  - SCAN → DONE_S, DONE_F, or IDLE (abort).
  - DONE_S / DONE_F → IDLE after one cycle.
- Request accept (IDLE & match_enable):
  - need = new_length[LEN_W-1:3] + 1, zero-extended to FREE_W and latched.
  - scan_idx = start_ptr; tick = 0; eval_cnt = 0; found = 0; best_amt = 0; match_best_sram = SRAM_NUM.
- SCAN, each cycle:
  - match_sram = scan_idx; scan_idx wraps SRAM_NUM-1 → 0.
  - tick increments, saturating at the max value.
  - A valid/index shift pipe of depth RSP_LAT tags each status response with its index. Only issues made in SCAN are valid.
- Evaluation of a valid response:
  - Candidate if accessible=1 AND free_space ≥ need.
  - Update best if found=0 OR packet_amount > best_amt. Strict comparison: on a tie the earliest in scan order is kept.
  - An update sets found=1, best_amt=packet_amount, match_best_sram=index.
  - eval_cnt increments per valid response and saturates at SRAM_NUM.
- Termination (registered found/eval_cnt, checked in SCAN, first match wins):
  1. match_enable=0 → IDLE, no pulse, match_best_sram=SRAM_NUM.
  2. found & tick ≥ match_threshold → DONE_S.
  3. found & early_exit_en & eval_cnt==SRAM_NUM → DONE_S.
  4. tick == match_timeout → DONE_F.
- DONE_S:
  - match_suc=1 for exactly one cycle.
  - match_best_sram is held until the next request accept.
  - start_ptr = best+1 (mod SRAM_NUM).
- DONE_F:
  - match_fail=1 for one cycle; match_best_sram=SRAM_NUM.
  - start_ptr = start_ptr+1 (mod SRAM_NUM).
- Pipeline: responses in flight when leaving SCAN are discarded; valids are cleared.
- match_enable still high in IDLE after DONE starts a new scan the following cycle. The front end must drop it on match_suc/match_fail.
- match_threshold=0: completes on the first cycle found is seen set.
- rst in any state returns to reset values the next cycle; an in-progress scan produces no pulse.
- match_suc and match_fail are never both high.

Decomposition:
- Shared package hydra_match_pkg holds:
  - match state enum (IDLE, SCAN, DONE_S, DONE_F);
  - SRAM_NUM default;
  - the "no SRAM" encoding;
  - a need-computation function (length → half-words).
- One natural sub-module: match_rsp_pipe, a parametrised RSP_LAT-deep valid+index shift register.

Test Plan:
1. Tie-break and best choice: SRAM_NUM=32, RSP_LAT=1, threshold=40, timeout=100, early_exit_en=0; all accessible, free=100, amounts 0 except SRAM 7=5 and SRAM 20=5; new_length=64 (need 9). Required: match_suc at tick 40, best=7, start_ptr→8.
2. Space check: new_length=255 (need 32); SRAM 3 free=31/amount=9, SRAM 4 free=32/amount=1, others inaccessible. Required: best=4, never 3.
3. Timeout: all inaccessible, timeout=50. Required: match_fail one cycle at tick 50, best=32, start_ptr advances by 1, match_suc never high.
4. Early exit: threshold=200, early_exit_en=1, RSP_LAT=3; SRAM 12 is the only candidate. Required: match_suc one cycle after eval_cnt reaches 32, best=12.
5. Abort and reset: drop match_enable mid-scan after SRAM 5 was found. Required: IDLE next cycle, no pulse, best=32. Repeat the scan with rst asserted instead; all outputs must return to reset values.
6. Back-to-back: hold match_enable through DONE_S. Required: new scan starts from best+1 with best reset to 32 at accept; the stale in-flight response from the prior scan is ignored.
